// File: rtl/bmp_stream_parser.sv
// Streaming BMP parser: validates the 54-byte header, skips to pixel data and
// emits 24-bit BGR-order triplets (first byte in [23:16]) while dropping row padding.
module bmp_stream_parser #(
   parameter int HEADER_SIZE = 54,
   parameter int PIXEL_WIDTH = 24
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [7:0]             in_dout,
   input  logic                   in_empty,
   output logic                   in_rd_en,
   output logic [PIXEL_WIDTH-1:0] out_din,
   input  logic                   out_full,
   output logic                   out_wr_en,
   output logic [31:0]            img_width,
   output logic [31:0]            img_height,
   output logic                   header_valid,
   output logic                   done,
   output logic                   error
);

   typedef enum logic [2:0] {
      S_HEADER = 3'd0,
      S_SKIP   = 3'd1,
      S_PIXEL  = 3'd2,
      S_PAD    = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   state_t      state_r, state_nxt_s;
   logic [15:0] hdr_idx_r;
   logic [7:0]  sig0_r, sig1_r;
   logic [31:0] offset_r, width_r, height_r;
   logic [15:0] bpp_r;
   logic [31:0] skip_cnt_r, col_r, row_r;
   logic [1:0]  tri_r;
   logic [7:0]  b_hi_r, b_mid_r;
   logic [23:0] pix_r;
   logic        pix_valid_r, header_valid_r, done_r, error_r;

   logic        hdr_last_s, hdr_bad_s, col_last_s, row_last_s, pad_s, cnt_last_s, pix_load_s;
   logic [1:0]  lane_s;

   assign hdr_last_s = (hdr_idx_r == 16'(HEADER_SIZE - 1));
   assign hdr_bad_s  = (sig0_r != 8'h42) || (sig1_r != 8'h4D) || (bpp_r != 16'd24) ||
                       (width_r == 32'd0) || (height_r == 32'd0) || height_r[31] ||
                       (offset_r < 32'(HEADER_SIZE));
   assign col_last_s = (col_r == width_r - 32'd1);
   assign row_last_s = (row_r == height_r - 32'd1);
   assign pad_s      = (width_r[1:0] != 2'd0);
   assign cnt_last_s = (skip_cnt_r == 32'd1);
   assign pix_load_s = (state_r == S_PIXEL) && in_rd_en && (tri_r == 2'd2);
   // Byte position inside each 4-byte little-endian field (fields start at ...10b)
   assign lane_s     = hdr_idx_r[1:0] - 2'd2;

   assign out_din      = pix_r;
   assign img_width    = width_r;
   assign img_height   = height_r;
   assign header_valid = header_valid_r;
   assign done         = done_r;
   assign error        = error_r;

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_r <= S_HEADER;
      else       state_r <= state_nxt_s;
   end

   // Next-state logic; every transition is qualified by an actual byte consume
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_HEADER: begin
            if (in_rd_en && hdr_last_s) begin
               if (hdr_bad_s)                          state_nxt_s = S_ERROR;
               else if (offset_r > 32'(HEADER_SIZE))   state_nxt_s = S_SKIP;
               else                                    state_nxt_s = S_PIXEL;
            end else begin
               state_nxt_s = S_HEADER;
            end
         end
         S_SKIP: begin
            if (in_rd_en && cnt_last_s) state_nxt_s = S_PIXEL;
            else                        state_nxt_s = S_SKIP;
         end
         S_PIXEL: begin
            if (pix_load_s && col_last_s) begin
               if (pad_s)           state_nxt_s = S_PAD;
               else if (row_last_s) state_nxt_s = S_DONE;
               else                 state_nxt_s = S_PIXEL;
            end else begin
               state_nxt_s = S_PIXEL;
            end
         end
         S_PAD: begin
            if (in_rd_en && cnt_last_s) begin
               if (row_r == height_r) state_nxt_s = S_DONE;
               else                   state_nxt_s = S_PIXEL;
            end else begin
               state_nxt_s = S_PAD;
            end
         end
         S_DONE:  state_nxt_s = S_DONE;
         S_ERROR: state_nxt_s = S_ERROR;
         default: state_nxt_s = S_ERROR;
      endcase
   end

   // FIFO handshakes; the third byte waits until the holding register can take it
   always_comb begin
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
      if (reset) begin
         in_rd_en  = 1'b0;
         out_wr_en = 1'b0;
      end else begin
         out_wr_en = pix_valid_r & ~out_full;
         case (state_r)
            S_HEADER, S_SKIP, S_PAD: in_rd_en = ~in_empty;
            S_PIXEL: in_rd_en = ~in_empty & ((tri_r != 2'd2) | ~pix_valid_r | ~out_full);
            default: in_rd_en = 1'b0;
         endcase
      end
   end

   // Header byte capture
   always_ff @(posedge clock) begin
      if (reset) begin
         hdr_idx_r <= 16'd0;
         sig0_r    <= 8'd0;
         sig1_r    <= 8'd0;
         offset_r  <= 32'd0;
         width_r   <= 32'd0;
         height_r  <= 32'd0;
         bpp_r     <= 16'd0;
      end else if ((state_r == S_HEADER) && in_rd_en) begin
         hdr_idx_r <= hdr_idx_r + 16'd1;
         case (hdr_idx_r) inside
            16'd0:            sig0_r <= in_dout;
            16'd1:            sig1_r <= in_dout;
            [16'd10:16'd13]:  offset_r[{lane_s, 3'b000} +: 8] <= in_dout;
            [16'd18:16'd21]:  width_r[{lane_s, 3'b000} +: 8]  <= in_dout;
            [16'd22:16'd25]:  height_r[{lane_s, 3'b000} +: 8] <= in_dout;
            [16'd28:16'd29]:  bpp_r[{hdr_idx_r[0], 3'b000} +: 8] <= in_dout;
            default: ;
         endcase
      end
   end

   // Skip/pad down-counter, pixel assembly, column/row counters and holding register
   always_ff @(posedge clock) begin
      if (reset) begin
         skip_cnt_r  <= 32'd0;
         tri_r       <= 2'd0;
         b_hi_r      <= 8'd0;
         b_mid_r     <= 8'd0;
         col_r       <= 32'd0;
         row_r       <= 32'd0;
         pix_r       <= 24'd0;
         pix_valid_r <= 1'b0;
      end else begin
         if ((state_r == S_HEADER) && (state_nxt_s == S_SKIP))
            skip_cnt_r <= offset_r - 32'(HEADER_SIZE);
         else if (((state_r == S_SKIP) || (state_r == S_PAD)) && in_rd_en)
            skip_cnt_r <= skip_cnt_r - 32'd1;
         else if (pix_load_s && col_last_s)
            skip_cnt_r <= {30'd0, width_r[1:0]};

         if ((state_r == S_PIXEL) && in_rd_en) begin
            case (tri_r)
               2'd0: begin b_hi_r  <= in_dout; tri_r <= 2'd1; end
               2'd1: begin b_mid_r <= in_dout; tri_r <= 2'd2; end
               default: begin
                  tri_r <= 2'd0;
                  if (col_last_s) begin
                     col_r <= 32'd0;
                     row_r <= row_r + 32'd1;
                  end else begin
                     col_r <= col_r + 32'd1;
                  end
               end
            endcase
         end

         if (pix_load_s) begin
            pix_r       <= {b_hi_r, b_mid_r, in_dout};
            pix_valid_r <= 1'b1;
         end else if (out_wr_en) begin
            pix_valid_r <= 1'b0;
         end
      end
   end

   // Sticky status flags
   always_ff @(posedge clock) begin
      if (reset) begin
         header_valid_r <= 1'b0;
         done_r         <= 1'b0;
         error_r        <= 1'b0;
      end else begin
         if ((state_r == S_HEADER) && ((state_nxt_s == S_SKIP) || (state_nxt_s == S_PIXEL)))
            header_valid_r <= 1'b1;
         if ((state_r == S_HEADER) && (state_nxt_s == S_ERROR))
            error_r <= 1'b1;
         if ((state_r == S_DONE) && !pix_valid_r)
            done_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bmp_stream_parser.sv
// Directed bench for bmp_stream_parser: a byte-queue source FIFO, an expected-pixel
// scoreboard queue and a monitor that checks every write on out_wr_en.
module tb_bmp_stream_parser;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  in_dout;
   logic        in_empty;
   logic        in_rd_en;
   logic [23:0] out_din;
   logic        out_full;
   logic        out_wr_en;
   logic [31:0] img_width, img_height;
   logic        header_valid, done, error;

   logic [7:0]  src_q[$];
   logic [23:0] exp_q[$];
   int          vec_cnt = 0;
   int          err_cnt = 0;
   int          wr_cnt  = 0;
   bit          rand_empty = 1'b0;
   bit          took = 1'b0;

   bmp_stream_parser #(.HEADER_SIZE(54), .PIXEL_WIDTH(24)) dut (
      .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
      .in_rd_en(in_rd_en), .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en),
      .img_width(img_width), .img_height(img_height), .header_valid(header_valid),
      .done(done), .error(error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Upstream FWFT FIFO model: pop what was taken, present head, sample rd_en before the edge
   initial begin
      in_empty = 1'b1;
      in_dout  = 8'h00;
      forever begin
         @(negedge clock);
         if (took && src_q.size() > 0) void'(src_q.pop_front());
         if (src_q.size() == 0 || (rand_empty && ($urandom_range(0, 1) == 1))) begin
            in_empty = 1'b1;
            in_dout  = 8'h00;
         end else begin
            in_empty = 1'b0;
            in_dout  = src_q[0];
         end
         #4;
         took = in_rd_en;
         if (in_rd_en) chk("rd_while_empty", {31'd0, in_empty}, 32'd0);
      end
   end

   // Scoreboard monitor
   initial begin
      forever begin
         @(negedge clock);
         #4;
         if (out_wr_en) begin
            wr_cnt++;
            if (reset) chk("wr_in_reset", {31'd0, out_wr_en}, 32'd0);
            else if (exp_q.size() == 0) chk("unexpected_write", out_din, 32'hFFFF_FFFF);
            else chk("pixel", {8'd0, out_din}, {8'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(negedge clock);
      #4;
   endtask

   task automatic push_pix(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      src_q.push_back(b0);
      src_q.push_back(b1);
      src_q.push_back(b2);
      exp_q.push_back({b0, b1, b2});
   endtask

   task automatic push_header(input int w, input int h, input int off,
                              input logic [7:0] b1, input int bpp);
      logic [7:0] v;
      for (int i = 0; i < 54; i++) begin
         v = 8'(i);
         if (i == 0) v = 8'h42;
         if (i == 1) v = b1;
         if (i >= 10 && i <= 13) v = 8'(off >> (8 * (i - 10)));
         if (i >= 18 && i <= 21) v = 8'(w >> (8 * (i - 18)));
         if (i >= 22 && i <= 25) v = 8'(h >> (8 * (i - 22)));
         if (i == 26) v = 8'h01;
         if (i == 27) v = 8'h00;
         if (i >= 28 && i <= 29) v = 8'(bpp >> (8 * (i - 28)));
         src_q.push_back(v);
      end
   endtask

   task automatic push_filler(input int n, input logic [7:0] v);
      for (int i = 0; i < n; i++) src_q.push_back(v);
   endtask

   task automatic push_image(input int w, input int h, input int seed);
      int k;
      k = 0;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            push_pix(8'(seed + 3 * k), 8'(seed + 3 * k + 1), 8'(seed + 3 * k + 2));
            k++;
         end
         push_filler(w % 4, 8'hEE);
      end
   endtask

   // mode 0: done, 1: error, 2: header_valid, 3: wr_cnt reaches target
   task automatic wait_for(input int mode, input int target, input int max_cycles, input string name);
      int  n;
      bit  hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < max_cycles) begin
         tick();
         n++;
         case (mode)
            0: hit = done;
            1: hit = error;
            2: hit = header_valid;
            default: hit = (wr_cnt >= target);
         endcase
      end
      chk(name, {31'd0, hit}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      src_q.delete();
      exp_q.delete();
      #4;
      chk("rst_rd_en", {31'd0, in_rd_en}, 32'd0);
      chk("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
      tick();
      chk("rst_state", {header_valid, done, error, 1'b0} | {4'd0, img_width[27:0]}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic finish_img(input string tag, input int w, input int h, input int trail);
      chk({tag, "_hv"},     {31'd0, header_valid}, 32'd1);
      chk({tag, "_width"},  img_width, 32'(w));
      chk({tag, "_height"}, img_height, 32'(h));
      chk({tag, "_error"},  {31'd0, error}, 32'd0);
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      repeat (5) tick();
      chk({tag, "_trail_left"}, 32'(src_q.size()), 32'(trail));
      chk({tag, "_rd_after"}, {31'd0, in_rd_en}, 32'd0);
   endtask

   task automatic error_case(input string tag, input logic [7:0] b1, input int bpp);
      push_header(4, 4, 54, b1, bpp);
      push_filler(6, 8'h77);
      wait_for(1, 0, 400, {tag, "_error"});
      repeat (5) tick();
      chk({tag, "_rd_en"}, {31'd0, in_rd_en}, 32'd0);
      chk({tag, "_hv"}, {31'd0, header_valid}, 32'd0);
      chk({tag, "_left"}, 32'(src_q.size()), 32'd6);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [23:0] held;
      int          base;
      reset    = 1'b1;
      out_full = 1'b0;
      repeat (3) tick();
      chk("reset_hv",    {31'd0, header_valid}, 32'd0);
      chk("reset_done",  {31'd0, done}, 32'd0);
      chk("reset_error", {31'd0, error}, 32'd0);
      chk("reset_width", img_width, 32'd0);
      chk("reset_wr",    {31'd0, out_wr_en}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // 720x540 header parse, first two pixels
      push_header(720, 540, 54, 8'h4D, 24);
      push_pix(8'h01, 8'h02, 8'h03);
      push_pix(8'hA4, 8'hB5, 8'hC6);
      wait_for(2, 0, 300, "big_hv");
      chk("big_width", img_width, 32'd720);
      chk("big_height", img_height, 32'd540);
      chk("big_error", {31'd0, error}, 32'd0);
      repeat (10) tick();
      chk("big_drained", 32'(exp_q.size()), 32'd0);
      do_reset();

      // 12x5, offset 54, no padding
      push_header(12, 5, 54, 8'h4D, 24);
      push_image(12, 5, 8'h11);
      push_filler(3, 8'h99);
      wait_for(0, 0, 2000, "plain_done");
      finish_img("plain", 12, 5, 3);
      do_reset();

      // 5x2, offset 58: 4 skipped bytes and 1 pad byte per row
      push_header(5, 2, 58, 8'h4D, 24);
      push_filler(4, 8'hCC);
      push_image(5, 2, 8'h40);
      push_filler(2, 8'h99);
      wait_for(0, 0, 1000, "pad_done");
      finish_img("pad", 5, 2, 2);
      do_reset();

      // Backpressure: hold out_full for 20 cycles mid-image
      push_header(8, 4, 54, 8'h4D, 24);
      push_image(8, 4, 8'h80);
      base = wr_cnt;
      wait_for(3, base + 5, 1000, "hold_start");
      @(negedge clock);
      out_full = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         #4;
         if (i == 6) held = out_din;
         if (i > 6) chk("hold_din_stable", {8'd0, out_din}, {8'd0, held});
         if (i >= 6) chk("hold_no_consume", {31'd0, in_rd_en}, 32'd0);
         chk("hold_no_write", {31'd0, out_wr_en}, 32'd0);
         @(negedge clock);
      end
      out_full = 1'b0;
      wait_for(0, 0, 1000, "hold_done");
      finish_img("hold", 8, 4, 0);
      do_reset();

      error_case("bad_sig", 8'h4E, 24);
      do_reset();
      error_case("bad_bpp", 8'h4D, 32);
      do_reset();

      // Same image as the plain case with a randomly starving source
      rand_empty = 1'b1;
      push_header(12, 5, 54, 8'h4D, 24);
      push_image(12, 5, 8'h11);
      push_filler(3, 8'h99);
      wait_for(0, 0, 5000, "rand_done");
      finish_img("rand", 12, 5, 3);
      rand_empty = 1'b0;
      do_reset();

      // Reset mid-image, then restream
      push_header(8, 4, 54, 8'h4D, 24);
      push_image(8, 4, 8'h22);
      base = wr_cnt;
      wait_for(3, base + 10, 1000, "midrst_progress");
      do_reset();
      push_header(8, 4, 54, 8'h4D, 24);
      push_image(8, 4, 8'h33);
      wait_for(0, 0, 1000, "restream_done");
      finish_img("restream", 8, 4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
